// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: the main pipeline always wins the write port, and aux
// results wait in a small FIFO. A pipe write kills older queued writes to the same register.
module rf_wb_arbiter #(
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        RegWrite,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  output logic [31:0] pend_mask,
  output logic        stall_req
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

  logic [4:0]        q_addr_q [QDEPTH];
  logic [4:0]        q_addr_d [QDEPTH];
  logic [31:0]       q_data_q [QDEPTH];
  logic [QDEPTH-1:0] live_q, live_d;
  logic [PW:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pend_q, pend_d;
  logic              stall_q;

  logic          full, empty, pipe_wr, accept, enq, pop;
  logic [PW-1:0] rd_idx, wr_idx;

  always_comb begin
    rd_idx  = rd_q[PW-1:0];
    wr_idx  = wr_q[PW-1:0];
    empty   = (rd_q == wr_q);
    full    = (rd_idx == wr_idx) && (rd_q[PW] != wr_q[PW]);
    pipe_wr = pipe_we && (pipe_addr != 5'd0);
    accept  = aux_valid && !full;
    enq     = accept && (aux_addr != 5'd0);
    pop     = !pipe_wr && !empty;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    wr_d    = enq ? wr_q + 1'b1 : wr_q;
  end

  assign aux_ready = !full;

  // Live bits are cleared on pop as well, so a set live bit always means an occupied slot.
  always_comb begin
    q_addr_d = q_addr_q;
    live_d   = live_q;
    if (pipe_wr) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (live_q[i] && (q_addr_q[i] == pipe_addr)) live_d[i] = 1'b0;
      end
    end
    if (pop) live_d[rd_idx] = 1'b0;
    if (enq) begin
      q_addr_d[wr_idx] = aux_addr;
      live_d[wr_idx]   = !(pipe_wr && (aux_addr == pipe_addr));
    end
    pend_d = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (live_d[i]) pend_d[q_addr_d[i]] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_wr) begin
      wen_d   = 1'b1;
      waddr_d = pipe_addr;
      wdata_d = pipe_data;
    end else if (pop) begin
      wen_d   = live_q[rd_idx];
      waddr_d = q_addr_q[rd_idx];
      wdata_d = q_data_q[rd_idx];
    end
  end

  // Non-empty with a pipe write is the only way the queue fails to pop.
  always_comb begin
    cnt_d = '0;
    if (!empty && pipe_wr) cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
      live_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      q_addr_q <= q_addr_d;
      if (enq) q_data_q[wr_idx] <= aux_data;
      live_q  <= live_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      stall_q <= (cnt_d == Limit);
    end
  end

  assign RegWrite  = wen_q;
  assign WriteAddr = waddr_q;
  assign WriteData = wdata_q;
  assign pend_mask = pend_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random bench for rf_wb_arbiter, checked against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int QDEPTH = 4;
  localparam int LIMIT  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [31:0] pend_mask;
  logic        stall_req;

  rf_wb_arbiter #(.QDEPTH(QDEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        live;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_starve;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model follows the arbitration rules on a plain queue.
  task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic        pw, rdy;
    int          sz;
    ent_t        e;
    logic [31:0] pm;
    pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    #1;
    rdy = (mq.size() < QDEPTH);
    chk("aux_ready", {31'd0, aux_ready}, {31'd0, rdy});
    pw = pwe && (pa != 5'd0);
    sz = mq.size();
    if (pw) begin
      foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
      m_we = 1'b1; m_wa = pa; m_wd = pd;
    end else if (sz > 0) begin
      e = mq.pop_front();
      m_we = e.live; m_wa = e.addr; m_wd = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (av && rdy && (aa != 5'd0)) begin
      e.addr = aa; e.data = ad; e.live = !(pw && (aa == pa));
      mq.push_back(e);
    end
    m_starve = (sz > 0 && pw) ? ((m_starve < LIMIT) ? m_starve + 1 : m_starve) : 0;
    @(posedge clk);
    #1;
    pm = '0;
    foreach (mq[i]) if (mq[i].live) pm[mq[i].addr] = 1'b1;
    chk("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
    chk("WriteAddr", {27'd0, WriteAddr}, {27'd0, m_wa});
    chk("WriteData", WriteData, m_wd);
    chk("pend_mask", pend_mask, pm);
    chk("stall_req", {31'd0, stall_req}, (m_starve == LIMIT) ? 32'd1 : 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_WriteAddr", {27'd0, WriteAddr}, 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);
    chk("rst_pend_mask", pend_mask, 32'd0);
    chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
    chk("rst_aux_ready", {31'd0, aux_ready}, 32'd1);
    mq.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_starve = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    aux_valid = 1'b0; aux_addr = '0; aux_data = '0;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single aux write with an idle pipe.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5A5A5);
    chk("pend5_set", {31'd0, pend_mask[5]}, 32'd1);
    idle();
    chk("aux5_we", {31'd0, RegWrite}, 32'd1);
    chk("aux5_data", WriteData, 32'hA5A5A5A5);
    chk("pend5_clr", {31'd0, pend_mask[5]}, 32'd0);
    idle();

    // Fill under continuous pipe writes, starve, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'd9, 32'h900 + i, 1'b1, 5'(i), 32'h100 + i);
    chk("full_not_ready", {31'd0, aux_ready}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 5'd9, 32'h990 + i, 1'b1, 5'd20, 32'hDEAD);
    chk("stall_set", {31'd0, stall_req}, 32'd1);
    step(1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("drain_addr", {27'd0, WriteAddr}, i);
    end
    idle();

    // WAW kill: dead slot pops without a write.
    step(1'b0, 5'd9, 32'd0, 1'b1, 5'd7, 32'h11);
    step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
    chk("waw_pend7", {31'd0, pend_mask[7]}, 32'd0);
    chk("waw_data", WriteData, 32'h22);
    idle();
    chk("waw_dead_pop", {31'd0, RegWrite}, 32'd0);

    // Address zero on both sides.
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    chk("zero_we", {31'd0, RegWrite}, 32'd0);
    chk("zero_pend", pend_mask, 32'd0);

    // Full queue, pop with aux_valid: rejected until ready, then accepted.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 32'h30 + i, 1'b1, 5'(10 + i), 32'h400 + i);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h415);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h416);
    for (int i = 0; i < 6; i++) idle();

    // Mid-operation reset with stall asserted.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd9, 32'h77, 1'b1, 5'(1 + i), 32'h500 + i);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd9, 32'h78, 1'b0, 5'd0, 32'd0);
    chk("pre_rst_stall", {31'd0, stall_req}, 32'd1);
    pipe_we = 1'b0; aux_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle();

    // Random traffic on a small address range to provoke kills and backpressure.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 8; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter QDEPTH, default 4, the number of aux write-back queue entries (power of two, 2..8).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, the number of consecutive cycles a non-empty queue may be blocked by pipe writes before stall_req asserts.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port pipe_we, input, 1, the main-pipeline write-back request; it has no backpressure.
REQ-006 The block SHALL have ports pipe_addr (input, 5) and pipe_data (input, 32), the main-pipeline destination register and value.
REQ-007 The block SHALL have port aux_valid, input, 1, the multi-cycle unit's write-back request.
REQ-008 The block SHALL have port aux_ready, output, 1, equal to !full, combinational.
REQ-009 The block SHALL have ports aux_addr (input, 5) and aux_data (input, 32), the multi-cycle unit's destination register and value.
REQ-010 The block SHALL have port RegWrite, output, 1, the registered register-file write enable.
REQ-011 The block SHALL have ports WriteAddr (output, 5) and WriteData (output, 32), the registered register-file write address and data.
REQ-012 The block SHALL have port pend_mask, output, 32, where bit i=1 iff a live queue entry targets register i; bit 0 is always 0.
REQ-013 The block SHALL have port stall_req, output, 1, a request for the pipeline to suppress pipe_we so that the queue can drain.

Function
REQ-014 The block SHALL accept an aux request on a cycle with aux_valid&&aux_ready; if aux_addr==0 the request SHALL be consumed and discarded, otherwise it SHALL be enqueued at the tail, FIFO order, live=1.
REQ-015 The block SHALL treat a pipe request as a write iff pipe_we&&pipe_addr!=0.
REQ-016 Per cycle, when a pipe write is present it SHALL win: next-edge RegWrite=1, WriteAddr=pipe_addr, WriteData=pipe_data, latency 1 cycle.
REQ-017 Otherwise, when the queue is non-empty, the block SHALL pop the head, and next-edge RegWrite SHALL equal the head's live bit with the head's addr/data.
REQ-018 Otherwise the block SHALL drive next-edge RegWrite=0, with WriteAddr/WriteData holding their previous values.
REQ-019 A WAW kill SHALL apply on a pipe write to X: every live queue entry with addr X SHALL be cleared to live=0 on that edge, including an entry enqueued on the same edge.
REQ-020 A dead entry SHALL still occupy a slot and be popped in order without a register write.
REQ-021 Simultaneous enqueue and pop in one cycle SHALL be allowed; occupancy SHALL be unchanged, and aux_ready SHALL reflect occupancy before the edge.
REQ-022 Pointers SHALL wrap modulo QDEPTH, with the full/empty distinction held by an extra pointer bit or count.
REQ-023 starve_cnt SHALL increment on cycles with queue non-empty and a pipe write present, saturating at STARVE_LIMIT, and SHALL clear on any pop or when the queue is empty.
REQ-024 stall_req SHALL be registered, =1 iff starve_cnt==STARVE_LIMIT.
REQ-025 If pipe_we is still asserted while stall_req=1, the pipe write SHALL still win (REQ-016); no request is ever dropped.
REQ-026 pend_mask SHALL reflect queue state after the current edge, updated on the same edge as enqueue, pop or kill.

Reset
REQ-027 On rst_n=0, asynchronously: queue empty, pointers 0, starve_cnt 0, RegWrite 0, WriteAddr 0, WriteData 0, pend_mask 0, stall_req 0; aux_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries with no write issued; the first write after release SHALL come from requests presented after release.

Verification
REQ-029 Aux enqueue (addr 5, data 0xA5A5A5A5) with an idle pipe -> the next cycle pend_mask[5]=1, and one cycle later RegWrite=1, WriteAddr=5, WriteData=0xA5A5A5A5, with pend_mask[5]=0 afterwards.
REQ-030 Fill 4 aux entries (addrs 1..4) under continuous pipe writes to addr 9 -> aux_ready=0 after the 4th; stall_req=1 after 8 blocked cycles; dropping pipe_we drains 1,2,3,4 in order.
REQ-031 Aux enqueue addr 7 with data 0x11, then a pipe write addr 7 with data 0x22 -> pend_mask[7] clears; exactly one write to 7 (0x22); the dead slot pops with RegWrite=0.
REQ-032 Aux addr 0 and pipe addr 0 with pipe_we=1 -> no enqueue, RegWrite stays 0, pend_mask=0.
REQ-033 Assert rst_n=0 with 3 entries queued and stall_req=1 -> all outputs 0 immediately, aux_ready=1; no writes occur after release.
REQ-034 Queue full, with a pop and aux_valid on the same cycle -> the new entry is accepted only when aux_ready=1 before the edge, and occupancy is never exceeded.
